// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 UART receiver with a single-entry holding register, frame-error and overrun pulses
`timescale 1ns/1ps
module uart_rx_capture #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);
    localparam int CPB  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    if (CPB < 16) begin : g_cpb_chk
        $error("uart_rx_capture: CLK_FREQ_HZ/BAUD_RATE must be at least 16");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          done_q, done_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          half_end, bit_end, take;

    assign rx_s     = sync_q[1];
    assign half_end = cnt_q == CW'(HALF - 1);
    assign bit_end  = cnt_q == CW'(CPB - 1);
    // done_q marks a completed byte one cycle after the stop sample; a full register can still be drained that cycle
    assign take     = done_q && (!valid_q || i_ready);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: if (half_end) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (bit_end) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = STOP;
            end
            STOP: if (bit_end) begin
                cnt_d   = '0;
                done_d  = rx_s;
                ferr_d  = !rx_s;
                state_d = rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        data_d  = take ? shift_q : data_q;
        valid_d = take || (valid_q && !i_ready);
        ovr_d   = done_q && valid_q && !i_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], i_rx};
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: vector table, directed corner sequences and random frames against a byte-queue model
`timescale 1ns/1ps
module tb_uart_rx_capture;
    localparam int CPB = 50000000 / 115200;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_rx = 1'b1;
    logic       i_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overrun, o_busy;

    uart_rx_capture dut (
        .clk(clk), .rst(rst), .i_rx(i_rx), .i_ready(i_ready),
        .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err),
        .o_overrun(o_overrun), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int checks = 0, failures = 0;
    int valid_hi = 0, ferr_n = 0, ovr_n = 0, both_n = 0, stab_n = 0, rise_edge = 0;
    logic [7:0] rxq[$];
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;

    // Passive observer: what the consumer receives and every pulse seen
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) valid_hi++;
            if (o_valid && i_ready) rxq.push_back(o_data);
            if (o_frame_err) ferr_n++;
            if (o_overrun) ovr_n++;
            if (o_frame_err && o_overrun) both_n++;
            if (pv && !pr && o_valid && o_data !== pd) stab_n++;
            if (o_valid && !pv) rise_edge = edge_cnt;
            pv = o_valid;
            pr = i_ready;
            pd = o_data;
        end else pv = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        i_rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_ok);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         hold_low;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t       vt[5];
    int         n_rx, n_vh, n_fe, n_ov, t0, base, fe0, exp_fe;
    logic [7:0] expq[$];
    logic [7:0] rd;
    logic       rok;

    initial begin
        vt[0] = '{8'h55, 1'b1, 0,    1'b1, 1'b0};
        vt[1] = '{8'h00, 1'b0, 2000, 1'b0, 1'b1};
        vt[2] = '{8'h7E, 1'b1, 0,    1'b1, 1'b0};
        vt[3] = '{8'hFF, 1'b1, 0,    1'b1, 1'b0};
        vt[4] = '{8'h81, 1'b1, 0,    1'b1, 1'b0};

        #2 rst = 1'b1;
        tick(3);
        chk("rst_data", o_data, 8'h00);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ferr", o_frame_err, 1'b0);
        chk("rst_ovr", o_overrun, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        rst = 1'b0;
        tick(5);

        for (int v = 0; v < 5; v++) begin
            n_rx = rxq.size(); n_vh = valid_hi; n_fe = ferr_n; n_ov = ovr_n;
            t0 = edge_cnt + 1;
            send_frame(vt[v].data, vt[v].stop_ok);
            if (vt[v].hold_low > 0) begin
                tick(vt[v].hold_low);
                chk("break_busy", o_busy, 1'b1);
                i_rx = 1'b1;
            end
            tick(10);
            chk("vec_busy_idle", o_busy, 1'b0);
            chk("vec_rx_count", rxq.size() - n_rx, vt[v].exp_valid);
            chk("vec_valid_cycles", valid_hi - n_vh, vt[v].exp_valid);
            chk("vec_frame_err", ferr_n - n_fe, vt[v].exp_ferr);
            chk("vec_overrun", ovr_n - n_ov, 0);
            if (vt[v].exp_valid && rxq.size() > n_rx) begin
                chk("vec_data", rxq[$], vt[v].data);
                chk_rng("vec_latency", rise_edge - t0, LAT - 1, LAT + 1);
            end
        end

        // Full holding register with a second byte arriving
        i_ready = 1'b0;
        n_rx = rxq.size(); n_fe = ferr_n; n_ov = ovr_n;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        tick(10);
        chk("ovr_valid_held", o_valid, 1'b1);
        chk("ovr_data_held", o_data, 8'hA3);
        chk("ovr_pulse_count", ovr_n - n_ov, 1);
        chk("ovr_no_ferr", ferr_n - n_fe, 0);
        chk("ovr_not_consumed", rxq.size() - n_rx, 0);
        i_ready = 1'b1;
        tick(3);
        chk("ovr_rx_count", rxq.size() - n_rx, 1);
        if (rxq.size() > n_rx) chk("ovr_rx_data", rxq[$], 8'hA3);
        chk("ovr_valid_clr", o_valid, 1'b0);

        // Glitch shorter than half a bit
        n_vh = valid_hi; n_fe = ferr_n;
        i_rx = 1'b0;
        tick(50);
        chk("false_start_busy", o_busy, 1'b1);
        tick(50);
        i_rx = 1'b1;
        tick(130);
        chk("false_start_idle", o_busy, 1'b0);
        chk("false_start_valid", valid_hi - n_vh, 0);
        chk("false_start_ferr", ferr_n - n_fe, 0);

        // Reset in the middle of bit 4 of 0xC3
        n_fe = ferr_n; n_ov = ovr_n;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
        i_rx = 1'b0;
        tick(CPB / 2);
        rst = 1'b1;
        i_rx = 1'b1;
        #1;
        chk("midrst_data", o_data, 8'h00);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_valid", o_valid, 1'b0);
        tick(5);
        rst = 1'b0;
        tick(20);
        chk("postrst_idle", o_busy, 1'b0);
        n_rx = rxq.size();
        send_frame(8'h3C, 1'b1);
        tick(10);
        chk("postrst_rx_count", rxq.size() - n_rx, 1);
        if (rxq.size() > n_rx) chk("postrst_data", rxq[$], 8'h3C);
        chk("postrst_no_pulses", (ferr_n - n_fe) + (ovr_n - n_ov), 0);

        // Random frames: good frames append to the expected queue, bad stops count as frame errors
        base = rxq.size(); fe0 = ferr_n; exp_fe = 0;
        for (int r = 0; r < 4; r++) begin
            rd = 8'($urandom);
            rok = $urandom_range(3) != 0;
            tick($urandom_range(40, 1));
            send_frame(rd, rok);
            if (rok) expq.push_back(rd);
            else begin
                exp_fe++;
                tick($urandom_range(300, 1));
                i_rx = 1'b1;
            end
        end
        tick(10);
        chk("rand_rx_count", rxq.size() - base, expq.size());
        foreach (expq[i]) if (rxq.size() > base + i) chk("rand_data", rxq[base + i], expq[i]);
        chk("rand_frame_err", ferr_n - fe0, exp_fe);

        chk("pulses_exclusive", both_n, 0);
        chk("data_stable_while_held", stab_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
